slot_result_judge: RTL and testbench
====================================

Name: slot_result_judge

Overview:
- Sits directly downstream of the reel state controller and consumes its three reel scroll offsets (0..239).
- On each spin it debits a bet, waits until all three reels have stopped moving, and quantizes each offset to a symbol index.
- It then classifies the outcome as none, pair or triple, updates a saturating credit counter, and presents the result over a valid/ready handshake to the score/LED display stage.
- Runs in the same slow clock domain as the reel controller, so each offset changes at most once per clk.

Parameters:
- REEL_H, 240, strip height in rows; offsets are in 0..REEL_H-1.
- SYM_H, 60, rows per symbol; REEL_H/SYM_H = 4 symbols, so indices are 2 bits.
- OFFSET, 30, row bias that puts the window centre on a symbol.
- SETTLE, 4, consecutive unchanged cycles needed to declare the reels stopped.
- MOTION_TO, 16, cycles allowed in ARM for motion to appear before the spin is abandoned.
- CW, 8, credit counter width.
- START_CREDIT, 10, credit value after reset.
- BET, 1, credit debited per spin.
- PAIR_PAY, 2, payout when exactly two symbols match.
- TRIPLE_PAY, 8, payout when all three symbols match.

Ports:
- clk  in  1  clock; same domain as the reel controller.
- rst  in  1  reset; one clock; asynchronous and active-low.
- spin_start  in  1  single-cycle pulse from the onepulse stage.
- a_pos  in  10  reel A offset.
- b_pos  in  10  reel B offset.
- c_pos  in  10  reel C offset.
- result_ready  in  1  consumer accepts the result.
- result_valid  out  1  result fields are valid.
- sym_a  out  2  reel A symbol index.
- sym_b  out  2  reel B symbol index.
- sym_c  out  2  reel C symbol index.
- win_code  out  2  0 = none, 1 = pair, 2 = triple; 3 is never driven.
- payout  out  CW  credits awarded this spin.
- credit  out  CW  current credit balance.
- busy  out  1  high in every state except IDLE.
- no_credit  out  1  high while credit < BET.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; credit = START_CREDIT.
  - result_valid, sym_a, sym_b, sym_c, win_code, payout all = 0.
  - Previous-position registers and all internal counters = 0.
- A reset mid-operation aborts the spin. The bet already debited is not refunded.
- IDLE:
  - spin_start with credit >= BET: credit -= BET, snapshot a/b/c_pos, go to ARM.
  - spin_start with credit < BET: ignored; no_credit stays high.
- ARM:
  - Any pos differing from the snapshot goes to SPIN and clears the stable counter.
  - If MOTION_TO cycles elapse with no change: credit += BET (refund), go to IDLE, no result is presented.
- SPIN:
  - Each cycle, compare each pos with its value from the previous cycle.
  - Any difference clears the stable counter; otherwise the counter increments.
  - When the counter reaches SETTLE-1 with the current cycle also unchanged, go to JUDGE. The reels must be stable for SETTLE consecutive cycles.
- JUDGE (exactly 1 cycle):
  - Symbol index: t = pos + OFFSET; if t >= REEL_H then t -= REEL_H; sym = t / SYM_H.
  - Implement the division as a compare chain; no divider.
  - All three symbols equal: win_code = 2, payout = TRIPLE_PAY.
  - Exactly two equal: win_code = 1, payout = PAIR_PAY.
  - Otherwise: win_code = 0, payout = 0.
  - credit += payout, saturating at 2^CW-1.
  - sym_a/b/c, win_code and payout are registered. Go to PRESENT.
- PRESENT:
  - result_valid = 1. All result fields and credit are held stable while valid && !ready.
  - On result_valid && result_ready: result_valid drops the next cycle, state returns to IDLE.
  - Result fields keep their last values until the next JUDGE.
- spin_start is ignored in every state except IDLE, including the cycle in which a handshake completes. Pulses are not queued.
- Latency: last position change -> result_valid is SETTLE+1 cycles (SETTLE cycles of stability, 1 JUDGE cycle, then valid).
- no_credit is combinational from credit and updates in the same cycle as credit.

Test Plan:
- Triple win: reset, spin_start; ramp positions for 5 cycles, then hold a=0, b=215, c=10 -> syms 0/0/0, win_code = 2, payout = 8, credit 10 -> 9 -> 17, result_valid exactly SETTLE+1 cycles after the last change.
- Pair win: hold a=35, b=90, c=60 -> syms 1/2/1, win_code = 1, payout = 2, credit 10 -> 11. Then hold result_ready low for 7 cycles -> all outputs stable, spin_start pulses ignored.
- Motion timeout: spin_start with positions frozen -> credit dips to 9, returns to 10 after 16 cycles, result_valid never rises, busy returns low.
- Credit exhaustion: START_CREDIT = 1, one losing spin (a=0, b=65, c=130) -> credit 0, no_credit = 1; a further spin_start leaves busy low and credit 0.
- Saturation: CW = 8, credit 250 before a triple -> credit 249 after the bet, then 255; payout still reports 8.
- Async reset in SPIN: assert rst low between clock edges -> state IDLE and credit = 10 immediately, without waiting for a clock edge. A single glitch of positions mid-SETTLE restarts the stable count (verify the extended latency).

Source files
------------

// File: rtl/slot_result_judge.sv
// slot_result_judge: debits a bet per spin, waits for the three reels to settle,
// quantizes each offset to a symbol, scores none/pair/triple, keeps a saturating
// credit balance and presents the result over valid/ready.
module slot_result_judge #(
  parameter int REEL_H       = 240,
  parameter int SYM_H        = 60,
  parameter int OFFSET       = 30,
  parameter int SETTLE       = 4,
  parameter int MOTION_TO    = 16,
  parameter int CW           = 8,
  parameter int START_CREDIT = 10,
  parameter int BET          = 1,
  parameter int PAIR_PAY     = 2,
  parameter int TRIPLE_PAY   = 8
) (
  input  logic          clk,
  input  logic          rst,          // active-low, asynchronous
  input  logic          spin_start,
  input  logic [9:0]    a_pos,
  input  logic [9:0]    b_pos,
  input  logic [9:0]    c_pos,
  input  logic          result_ready,
  output logic          result_valid,
  output logic [1:0]    sym_a,
  output logic [1:0]    sym_b,
  output logic [1:0]    sym_c,
  output logic [1:0]    win_code,
  output logic [CW-1:0] payout,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          no_credit
);

  localparam int CNTW = $clog2((MOTION_TO > SETTLE ? MOTION_TO : SETTLE) + 1);
  localparam int NSYM = REEL_H / SYM_H;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SPIN, S_JUDGE, S_PRESENT} state_e;

  state_e          state_q;
  logic [CW-1:0]   credit_q;
  logic [9:0]      pa_q, pb_q, pc_q;   // snapshot in ARM, previous cycle in SPIN
  logic [CNTW-1:0] cnt_q;              // motion timeout in ARM, stable count in SPIN
  logic            valid_q;
  logic [1:0]      sa_q, sb_q, sc_q, win_q;
  logic [CW-1:0]   pay_q;

  // Offset -> symbol: add bias, wrap once, then a threshold compare chain.
  function automatic logic [1:0] quant(input logic [9:0] p);
    logic [10:0] t;
    logic [1:0]  s;
    t = {1'b0, p} + 11'(OFFSET);
    if (t >= 11'(REEL_H)) t = t - 11'(REEL_H);
    s = '0;
    for (int k = 1; k < NSYM; k++)
      if (t >= 11'(k * SYM_H)) s = 2'(k);
    return s;
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  logic       moved;
  logic [1:0] sa_d, sb_d, sc_d, win_d;
  logic [CW-1:0] pay_d;

  assign moved = (a_pos != pa_q) || (b_pos != pb_q) || (c_pos != pc_q);

  // Score the settled positions held in the previous-position registers.
  always_comb begin
    sa_d  = quant(pa_q);
    sb_d  = quant(pb_q);
    sc_d  = quant(pc_q);
    win_d = 2'd0;
    pay_d = '0;
    if (sa_d == sb_d && sb_d == sc_d) begin
      win_d = 2'd2;
      pay_d = CW'(TRIPLE_PAY);
    end else if (sa_d == sb_d || sb_d == sc_d || sa_d == sc_d) begin
      win_d = 2'd1;
      pay_d = CW'(PAIR_PAY);
    end
  end

  // Spin sequencer: bet, wait for motion, wait for settle, judge, present.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= CW'(START_CREDIT);
      pa_q     <= '0;
      pb_q     <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      sa_q     <= '0;
      sb_q     <= '0;
      sc_q     <= '0;
      win_q    <= '0;
      pay_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (spin_start && !no_credit) begin
          credit_q <= credit_q - CW'(BET);
          pa_q     <= a_pos;
          pb_q     <= b_pos;
          pc_q     <= c_pos;
          cnt_q    <= '0;
          state_q  <= S_ARM;
        end
        S_ARM: begin
          if (moved) begin
            pa_q    <= a_pos;
            pb_q    <= b_pos;
            pc_q    <= c_pos;
            cnt_q   <= '0;
            state_q <= S_SPIN;
          end else if (cnt_q == CNTW'(MOTION_TO - 1)) begin
            // Reels never moved: give the bet back and drop the spin.
            credit_q <= sat_add(credit_q, CW'(BET));
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SPIN: begin
          pa_q <= a_pos;
          pb_q <= b_pos;
          pc_q <= c_pos;
          if (moved) begin
            cnt_q <= '0;
          end else if (cnt_q == CNTW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= S_JUDGE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_JUDGE: begin
          sa_q     <= sa_d;
          sb_q     <= sb_d;
          sc_q     <= sc_d;
          win_q    <= win_d;
          pay_q    <= pay_d;
          credit_q <= sat_add(credit_q, pay_d);
          valid_q  <= 1'b1;
          state_q  <= S_PRESENT;
        end
        S_PRESENT: if (result_ready) begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_valid = valid_q;
  assign sym_a        = sa_q;
  assign sym_b        = sb_q;
  assign sym_c        = sc_q;
  assign win_code     = win_q;
  assign payout       = pay_q;
  assign credit       = credit_q;
  assign busy         = (state_q != S_IDLE);
  assign no_credit    = (credit_q < CW'(BET));

endmodule

// File: tb/tb_slot_result_judge.sv
// Scoreboard bench for slot_result_judge: directed test-plan spins plus
// randomized spins, expectations from a plain arithmetic model.
module tb_slot_result_judge;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst, spin_start, result_ready;
  logic [9:0] a_pos, b_pos, c_pos;
  logic       result_valid, busy, no_credit;
  logic [1:0] sym_a, sym_b, sym_c, win_code;
  logic [7:0] payout, credit;

  slot_result_judge dut (
    .clk(clk), .rst(rst), .spin_start(spin_start),
    .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos),
    .result_ready(result_ready), .result_valid(result_valid),
    .sym_a(sym_a), .sym_b(sym_b), .sym_c(sym_c), .win_code(win_code),
    .payout(payout), .credit(credit), .busy(busy), .no_credit(no_credit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int sa; int sb; int sc; int win; int pay; int cred; int vcyc;} exp_t;
  exp_t q[$];

  int vectors = 0, miscompares = 0;
  int m_credit = 10;
  int pa = 0, pb = 0, pc = 0, lastchg = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: symbol from the window-centre row.
  function automatic int msym(input int p);
    return ((p + 30) % 240) / 60;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setpos(input int a, input int b, input int c);
    if (a != pa || b != pb || c != pc) lastchg = cyc + 1;  // edge that samples it
    pa = a; pb = b; pc = c;
    a_pos = 10'(a); b_pos = 10'(b); c_pos = 10'(c);
  endtask

  // Monitor: pops one expectation per presented result and rechecks while held.
  exp_t cur;
  bit   have = 0;
  always @(negedge clk) begin
    if (!rst) have = 0;
    else if (result_valid) begin
      if (!have) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          cur = q.pop_front();
          have = 1;
          chk("latency", cyc, cur.vcyc);
        end
      end
      if (have) begin
        chk("sym_a", int'(sym_a), cur.sa);
        chk("sym_b", int'(sym_b), cur.sb);
        chk("sym_c", int'(sym_c), cur.sc);
        chk("win_code", int'(win_code), cur.win);
        chk("payout", int'(payout), cur.pay);
        chk("credit_held", int'(credit), cur.cred);
        if (result_ready) have = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; spin_start = 1'b0; result_ready = 1'b0;
    q.delete();
    m_credit = 10;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic do_spin(input int fa, input int fb, input int fc,
                         input int ramp, input int glitch, input int hold);
    bit ok;
    exp_t e;
    int m, pay, win;
    ok = (m_credit >= 1);
    spin_start = 1'b1; tick(); spin_start = 1'b0;
    if (!ok) begin
      chk("ignored_busy", int'(busy), 0);
      chk("ignored_credit", int'(credit), m_credit);
      return;
    end
    m_credit -= 1;
    chk("bet_debit", int'(credit), m_credit);
    chk("busy_spin", int'(busy), 1);
    for (int r = 0; r < ramp; r++) begin
      setpos((pa + 1 + $urandom_range(0, 6)) % 240, $urandom_range(0, 239), pc);
      tick();
    end
    setpos(fa, fb, fc);
    if (glitch != 0) begin
      tick(); tick();
      setpos(fa, (fb + 1) % 240, fc);
      tick();
      setpos(fa, fb, fc);
    end
    e.sa = msym(fa); e.sb = msym(fb); e.sc = msym(fc);
    m = (e.sa == e.sb) + (e.sb == e.sc) + (e.sa == e.sc);
    win = (m == 3) ? 2 : (m == 1) ? 1 : 0;
    pay = (win == 2) ? 8 : (win == 1) ? 2 : 0;
    m_credit = (m_credit + pay > 255) ? 255 : m_credit + pay;
    e.win = win; e.pay = pay; e.cred = m_credit; e.vcyc = lastchg + SETTLE + 1;
    q.push_back(e);
    for (int w = 0; w < 60 && !result_valid; w++) tick();
    chk("valid_timeout", int'(result_valid), 1);
    if (!result_valid) return;
    for (int i = 0; i < hold; i++) begin
      spin_start = (i == 1);
      tick();
    end
    result_ready = 1'b1; spin_start = 1'b1;
    tick();
    result_ready = 1'b0; spin_start = 1'b0;
    chk("valid_dropped", int'(result_valid), 0);
    chk("busy_idle", int'(busy), 0);
    chk("credit_after", int'(credit), m_credit);
  endtask

  int bl[10] = '{0, 29, 30, 209, 210, 239, 89, 90, 149, 150};
  function automatic int rpos();
    if ($urandom_range(0, 3) == 0) return bl[$urandom_range(0, 9)];
    return (int'($urandom_range(0, 3)) * 60 + int'($urandom_range(0, 59)) + 210) % 240;
  endfunction

  initial begin
    rst = 1'b0; spin_start = 1'b0; result_ready = 1'b0;
    a_pos = '0; b_pos = '0; c_pos = '0;
    tick(); tick();
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_syms", int'({sym_a, sym_b, sym_c}), 0);
    chk("rst_win", int'(win_code), 0);
    chk("rst_payout", int'(payout), 0);
    chk("rst_credit", int'(credit), 10);
    chk("rst_busy", int'(busy), 0);
    chk("rst_no_credit", int'(no_credit), 0);
    rst = 1'b1;
    tick();

    // Exhaust credit with losing spins, then a spin must be refused.
    for (int i = 0; i < 10; i++) do_spin(0, 65, 130, 1 + $urandom_range(0, 2), 0, 0);
    chk("exhaust_credit", int'(credit), 0);
    chk("exhaust_no_credit", int'(no_credit), 1);
    do_spin(5, 5, 5, 1, 0, 0);
    chk("exhaust_still_zero", int'(credit), 0);

    do_reset();
    do_spin(0, 215, 10, 5, 0, 0);             // triple
    chk("triple_credit", int'(credit), 17);
    do_spin(35, 90, 60, 3, 0, 7);             // pair, ready held low
    chk("pair_credit", int'(credit), 18);

    // Motion timeout: frozen reels get the bet refunded after 16 cycles.
    spin_start = 1'b1; tick(); spin_start = 1'b0;
    chk("to_dip", int'(credit), m_credit - 1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_still_dipped", int'(credit), m_credit - 1);
    chk("to_busy", int'(busy), 1);
    tick();
    chk("to_refund", int'(credit), m_credit);
    chk("to_idle", int'(busy), 0);

    do_spin(100, 100, 200, 2, 1, 1);          // glitch mid-settle

    // Asynchronous reset while spinning.
    spin_start = 1'b1; tick(); spin_start = 1'b0;
    setpos((pa + 3) % 240, pb, pc); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_credit", int'(credit), 10);
    chk("arst_valid", int'(result_valid), 0);
    q.delete(); m_credit = 10;
    tick(); rst = 1'b1; tick();

    for (int i = 0; i < 40; i++)
      do_spin(rpos(), rpos(), rpos(), $urandom_range(1, 6),
              ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 4));

    // Climb to 250, then a triple saturates at 255.
    do_reset();
    while (m_credit < 250) begin
      if (250 - m_credit >= 7) do_spin(0, 215, 10, 1, 0, 0);
      else do_spin(35, 90, 60, 1, 0, 0);
    end
    chk("sat_pre", int'(credit), 250);
    do_spin(0, 215, 10, 2, 0, 0);
    chk("sat_credit", int'(credit), 255);
    do_spin(0, 215, 10, 2, 0, 0);
    chk("sat_hold", int'(credit), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
